// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline register with a RUN/HALTED control FSM and a saturating retire counter.
// Define MEM_WB_FWD_EN to expose the fwdValid/fwdReg/fwdData forwarding outputs.
module mem_wb_stage #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stall,
    input  logic             flush,
    input  logic             in_valid,
    input  logic [15:0]      readData,
    input  logic [15:0]      aluResult,
    input  logic [15:0]      pcPlus2,
    input  logic [1:0]       wbSel,
    input  logic [2:0]       writeReg,
    input  logic             RegWrite,
    input  logic             halt,
    input  logic             data_memory_dump,
    output logic [15:0]      wbData,
    output logic [2:0]       wbReg,
    output logic             wbRegWrite,
    output logic             wb_valid,
    output logic             halted,
    output logic [CNT_W-1:0] retired
`ifdef MEM_WB_FWD_EN
    ,
    output logic             fwdValid,
    output logic [2:0]       fwdReg,
    output logic [15:0]      fwdData
`endif
);

    localparam int DATA_W = 16;
    localparam logic [0:0] ST_RUN    = 1'b0;
    localparam logic [0:0] ST_HALTED = 1'b1;

    logic [0:0]        state;
    logic              vld_p0;
    logic              rw_p0;
    logic              blk_p0;
    logic [DATA_W-1:0] data_p0;
    logic [2:0]        reg_p0;
    logic [CNT_W-1:0]  cnt;
    logic [DATA_W-1:0] wb_mux;
    logic              halt_flag;

    function automatic logic [DATA_W-1:0] sel_wb(
        input logic [1:0]        sel,
        input logic [DATA_W-1:0] alu,
        input logic [DATA_W-1:0] mem,
        input logic [DATA_W-1:0] pc
    );
        case (sel)
            2'b01:   return mem;
            2'b10:   return pc;
            default: return alu;
        endcase
    endfunction

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        return (&c) ? c : c + {{(CNT_W-1){1'b0}}, 1'b1};
    endfunction

    assign wb_mux    = sel_wb(wbSel, aluResult, readData, pcPlus2);
    assign halt_flag = halt | data_memory_dump;

    // Stage p0: priority is halted freeze > flush > stall > capture
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= ST_RUN;
            vld_p0  <= 1'b0;
            rw_p0   <= 1'b0;
            blk_p0  <= 1'b0;
            data_p0 <= '0;
            reg_p0  <= '0;
            cnt     <= '0;
        end else if (state == ST_HALTED) begin
            // Halting entry keeps its write for one cycle, then writes are blocked for good.
            blk_p0 <= 1'b1;
        end else if (flush) begin
            vld_p0 <= 1'b0;
            rw_p0  <= 1'b0;
        end else if (!stall) begin
            vld_p0  <= in_valid;
            rw_p0   <= RegWrite & in_valid;
            data_p0 <= wb_mux;
            reg_p0  <= writeReg;
            if (in_valid) begin
                cnt <= sat_inc(cnt);
                if (halt_flag) begin
                    state <= ST_HALTED;
                end
            end
        end
    end

    assign wbData     = data_p0;
    assign wbReg      = reg_p0;
    assign wb_valid   = vld_p0;
    assign wbRegWrite = vld_p0 & rw_p0 & ~blk_p0;
    assign halted     = (state == ST_HALTED);
    assign retired    = cnt;

`ifdef MEM_WB_FWD_EN
    assign fwdValid = wbRegWrite;
    assign fwdReg   = reg_p0;
    assign fwdData  = data_p0;
`endif

endmodule

// File: tb/tb_mem_wb_stage.sv
// Scoreboard bench for mem_wb_stage built with a 4-bit retire counter.
module tb_mem_wb_stage;

    localparam int CNT_W = 4;

    logic             clk;
    logic             rst;
    logic             stall;
    logic             flush;
    logic             in_valid;
    logic [15:0]      readData;
    logic [15:0]      aluResult;
    logic [15:0]      pcPlus2;
    logic [1:0]       wbSel;
    logic [2:0]       writeReg;
    logic             RegWrite;
    logic             halt;
    logic             data_memory_dump;
    logic [15:0]      wbData;
    logic [2:0]       wbReg;
    logic             wbRegWrite;
    logic             wb_valid;
    logic             halted;
    logic [CNT_W-1:0] retired;

    typedef struct packed {
        logic [15:0]      data;
        logic [2:0]       rg;
        logic             we;
        logic             vld;
        logic             hlt;
        logic [CNT_W-1:0] ret;
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;

    mem_wb_stage #(.CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush), .in_valid(in_valid),
        .readData(readData), .aluResult(aluResult), .pcPlus2(pcPlus2), .wbSel(wbSel),
        .writeReg(writeReg), .RegWrite(RegWrite), .halt(halt),
        .data_memory_dump(data_memory_dump), .wbData(wbData), .wbReg(wbReg),
        .wbRegWrite(wbRegWrite), .wb_valid(wb_valid), .halted(halted), .retired(retired)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic exp_t observed();
        exp_t o;
        o.data = wbData;
        o.rg   = wbReg;
        o.we   = wbRegWrite;
        o.vld  = wb_valid;
        o.hlt  = halted;
        o.ret  = retired;
        return o;
    endfunction

    function automatic exp_t mk(input logic [15:0] d, input logic [2:0] r, input logic we,
                                input logic v, input logic h, input logic [CNT_W-1:0] c);
        exp_t e;
        e.data = d; e.rg = r; e.we = we; e.vld = v; e.hlt = h; e.ret = c;
        return e;
    endfunction

    task automatic drive(input logic st, input logic fl, input logic v, input logic [1:0] sel,
                         input logic [15:0] mem, input logic [15:0] alu, input logic [15:0] pc,
                         input logic [2:0] r, input logic rw, input logic h, input logic dmp);
        stall = st; flush = fl; in_valid = v; wbSel = sel; readData = mem;
        aluResult = alu; pcPlus2 = pc; writeReg = r; RegWrite = rw; halt = h;
        data_memory_dump = dmp;
    endtask

    task automatic test_reset();
        exp_t e;
        exp_t o;
        rst = 1'b1;
        drive(0, 0, 1, 2'b01, 16'hFFFF, 16'hFFFF, 16'hFFFF, 3'd7, 1, 0, 0);
        repeat (2) @(posedge clk);
        #1;
        e = mk(16'h0, 3'd0, 0, 0, 0, 0);
        o = observed();
        checks++;
        if (o !== e) begin
            failures++;
            $display("FAIL reset_state got=%h exp=%h", o, e);
        end
        rst = 1'b0;
    endtask

    // Each cycle: drive, push expectation, clock, pop and compare.
    task automatic cycle_check(input string name);
        exp_t e;
        exp_t o;
        @(posedge clk);
        #1;
        o = observed();
        checks++;
        if (sb.size() == 0) begin
            failures++;
            $display("FAIL %s got=%h exp=<scoreboard empty>", name, o);
        end else begin
            e = sb.pop_front();
            if (o !== e) begin
                failures++;
                $display("FAIL %s got=%h exp=%h", name, o, e);
            end
        end
    endtask

    task automatic test_load();
        drive(0, 0, 1, 2'b01, 16'hBEEF, 16'h1111, 16'h2222, 3'd5, 1, 0, 0);
        sb.push_back(mk(16'hBEEF, 3'd5, 1, 1, 0, 1));
        cycle_check("load_capture");
    endtask

    task automatic test_wbsel();
        drive(0, 0, 1, 2'b00, 16'hAAAA, 16'h1234, 16'h3333, 3'd2, 1, 0, 0);
        sb.push_back(mk(16'h1234, 3'd2, 1, 1, 0, 2));
        cycle_check("wbsel_00_alu");
        drive(0, 0, 1, 2'b11, 16'hAAAA, 16'h5678, 16'h3333, 3'd3, 0, 0, 0);
        sb.push_back(mk(16'h5678, 3'd3, 0, 1, 0, 3));
        cycle_check("wbsel_11_alu_nowrite");
        drive(0, 0, 0, 2'b00, 16'hAAAA, 16'h9999, 16'h3333, 3'd7, 1, 1, 1);
        sb.push_back(mk(16'h9999, 3'd7, 0, 0, 0, 3));
        cycle_check("bubble_capture");
    endtask

    task automatic test_stall();
        drive(0, 0, 1, 2'b10, 16'hAAAA, 16'hBBBB, 16'h0042, 3'd1, 1, 0, 0);
        sb.push_back(mk(16'h0042, 3'd1, 1, 1, 0, 4));
        cycle_check("wbsel_10_pc");
        for (int i = 0; i < 2; i++) begin
            drive(1, 0, 1, 2'b00, 16'hAAAA, 16'hAAAA + 16'(i), 16'h0, 3'd6, 1, 0, 0);
            sb.push_back(mk(16'h0042, 3'd1, 1, 1, 0, 4));
            cycle_check("stall_hold");
        end
    endtask

    task automatic test_flush();
        drive(1, 1, 1, 2'b00, 16'h0, 16'hBBBB, 16'h0, 3'd4, 1, 0, 0);
        sb.push_back(mk(16'h0042, 3'd1, 0, 0, 0, 4));
        cycle_check("flush_with_stall");
        drive(0, 1, 1, 2'b00, 16'h0, 16'hCCCC, 16'h0, 3'd5, 1, 1, 0);
        sb.push_back(mk(16'h0042, 3'd1, 0, 0, 0, 4));
        cycle_check("flush_blocks_halt");
        drive(0, 0, 1, 2'b01, 16'h1111, 16'h0, 16'h0, 3'd0, 1, 0, 0);
        sb.push_back(mk(16'h1111, 3'd0, 1, 1, 0, 5));
        cycle_check("capture_after_flush");
    endtask

    task automatic test_saturation();
        int c;
        for (int i = 0; i < 20; i++) begin
            c = (6 + i > 15) ? 15 : 6 + i;
            drive(0, 0, 1, 2'b00, 16'h0, 16'(i), 16'h0, 3'(i % 8), 1, 0, 0);
            sb.push_back(mk(16'(i), 3'(i % 8), 1, 1, 0, CNT_W'(c)));
            cycle_check("retire_saturate");
        end
    endtask

    task automatic test_halt();
        drive(0, 0, 1, 2'b00, 16'h0, 16'hCAFE, 16'h0, 3'd2, 0, 1, 0);
        sb.push_back(mk(16'hCAFE, 3'd2, 0, 1, 1, 15));
        cycle_check("halt_entry");
        for (int i = 0; i < 3; i++) begin
            drive(i == 1, i == 2, 1, 2'b01, 16'h1000 + 16'(i), 16'h0, 16'h0, 3'd6, 1, 0, 0);
            sb.push_back(mk(16'hCAFE, 3'd2, 0, 1, 1, 15));
            cycle_check("halted_frozen");
        end
    endtask

    task automatic test_async_reset();
        exp_t o;
        exp_t e;
        rst = 1'b1;
        #2;
        e = mk(16'h0, 3'd0, 0, 0, 0, 0);
        o = observed();
        checks++;
        if (o !== e) begin
            failures++;
            $display("FAIL async_reset_immediate got=%h exp=%h", o, e);
        end
        drive(1, 0, 1, 2'b01, 16'h5555, 16'h0, 16'h0, 3'd4, 1, 1, 0);
        @(posedge clk);
        #1;
        o = observed();
        checks++;
        if (o !== e) begin
            failures++;
            $display("FAIL reset_held_discard got=%h exp=%h", o, e);
        end
        rst = 1'b0;
    endtask

    task automatic test_dump_halt();
        drive(0, 0, 1, 2'b00, 16'h0, 16'h0777, 16'h0, 3'd3, 1, 0, 1);
        sb.push_back(mk(16'h0777, 3'd3, 1, 1, 1, 1));
        cycle_check("dump_halt_own_write");
        drive(0, 0, 1, 2'b00, 16'h0, 16'h0888, 16'h0, 3'd5, 1, 0, 0);
        sb.push_back(mk(16'h0777, 3'd3, 0, 1, 1, 1));
        cycle_check("halted_write_blocked");
    endtask

    initial begin
        drive(0, 0, 0, 2'b00, 16'h0, 16'h0, 16'h0, 3'd0, 0, 0, 0);
        test_reset();
        test_load();
        test_wbsel();
        test_stall();
        test_flush();
        test_saturation();
        test_halt();
        test_async_reset();
        test_dump_halt();
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain got=%0d exp=0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
